// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl_pkg
// Description : Shared state encodings, address constants and the fetch
//               address-legality helper for the fetch PC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_ctrl_pkg;

  // Fetch sequencer states: one idle cycle after reset, then request/wait.
  typedef enum logic [1:0] {
    FPC_BOOT = 2'd0,
    FPC_RUN  = 2'd1,
    FPC_WAIT = 2'd2
  } fpc_state_e;

  localparam logic [31:0] c_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] c_EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] c_IM_LO     = 32'h0000_3000;
  localparam logic [31:0] c_IM_HI     = 32'h0000_4ffc;

  // A fetch address is illegal when it is not word aligned or falls outside
  // the instruction memory window [lo, hi].
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_buf
// Description : Holds a branch/jump target that arrived while the delay-slot
//               fetch was still outstanding, until that fetch completes.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set,
  input  logic [31:0] i_tgt,
  input  logic        i_consume,
  input  logic        i_clear,
  output logic        o_pend_v,
  output logic [31:0] o_pend_tgt
);

  logic        r_pend_v;
  logic [31:0] r_pend_tgt;

  // Clear (exception/eret) beats set, set beats consume; the target is only
  // captured on set so a stale value is harmless once the valid bit drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 32'h0000_0000;
    end else if (i_clear) begin
      r_pend_v   <= 1'b0;
    end else if (i_set) begin
      r_pend_v   <= 1'b1;
      r_pend_tgt <= i_tgt;
    end else if (i_consume) begin
      r_pend_v   <= 1'b0;
    end
  end

  assign o_pend_v   = r_pend_v;
  assign o_pend_tgt = r_pend_tgt;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch PC register and sequencer. Selects between PC+4, the
//               ID-stage redirect target, exception entry and eret return,
//               honouring stalls, the IM ready handshake and the delay slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] EXC_ENTRY = c_EXC_ENTRY,
  parameter logic [31:0] IM_LO     = c_IM_LO,
  parameter logic [31:0] IM_HI     = c_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        im_rdy,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        if_valid,
  output logic        fetch_adel
);

  fpc_state_e  r_state;
  fpc_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_4;
  logic        w_fetch_done;
  logic        w_pend_set;
  logic        w_pend_consume;
  logic        w_pend_clear;
  logic        w_pend_v;
  logic [31:0] w_pend_tgt;

  assign w_pc_4       = r_pc + 32'd4;
  assign im_req       = (r_state != FPC_BOOT);
  assign w_fetch_done = im_req & im_rdy & ~stall;

  fetch_redirect_buf u_redirect_buf (
    .clk        (clk),
    .rst        (reset),
    .i_set      (w_pend_set),
    .i_tgt      (jump_target),
    .i_consume  (w_pend_consume),
    .i_clear    (w_pend_clear),
    .o_pend_v   (w_pend_v),
    .o_pend_tgt (w_pend_tgt)
  );

  // Next state tracks the IM handshake; the PC source chain is strictly
  // prioritised, with exception/eret overriding stall and the open fetch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_set     = 1'b0;
    w_pend_consume = 1'b0;
    w_pend_clear   = 1'b0;

    case (r_state)
      FPC_BOOT: w_state_nxt = FPC_RUN;
      FPC_RUN,
      FPC_WAIT: w_state_nxt = im_rdy ? FPC_RUN : FPC_WAIT;
      default:  w_state_nxt = FPC_BOOT;
    endcase

    if (exc_req) begin
      w_pc_nxt     = EXC_ENTRY;
      w_pend_clear = 1'b1;
      w_state_nxt  = FPC_RUN;
    end else if (eret_req) begin
      w_pc_nxt     = epc;
      w_pend_clear = 1'b1;
      w_state_nxt  = FPC_RUN;
    end else if (jump_valid && !stall && w_fetch_done) begin
      // The fetch finishing now is the delay slot, so redirect right away.
      w_pc_nxt = jump_target;
    end else if (jump_valid && !stall) begin
      // Delay slot still outstanding: park the target until it completes.
      w_pend_set = 1'b1;
    end else if (w_pend_v && w_fetch_done) begin
      w_pc_nxt       = w_pend_tgt;
      w_pend_consume = 1'b1;
    end else if (w_fetch_done) begin
      w_pc_nxt = w_pc_4;
    end
  end

  // State and PC registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FPC_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign pc         = r_pc;
  assign pc_4       = w_pc_4;
  assign im_addr    = r_pc;
  assign if_valid   = w_fetch_done & ~exc_req & ~eret_req;
  assign fetch_adel = im_req & addr_bad(r_pc, IM_LO, IM_HI);

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Directed self-checking bench for fetch_pc_ctrl using an
//               expected-value queue and immediate assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        im_rdy;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        if_valid;
  logic        fetch_adel;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  fetch_pc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .im_rdy      (im_rdy),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .pc          (pc),
    .pc_4        (pc_4),
    .if_valid    (if_valid),
    .fetch_adel  (fetch_adel)
  );

  // 10 ns core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock of stimulus: drive, check if_valid combinationally, then check
  // the PC that the edge produced.
  task automatic cyc(input string tag, input logic st, input logic jv,
                     input logic [31:0] jt, input logic exc, input logic eret,
                     input logic [31:0] ep, input logic rdy,
                     input logic exp_ifv, input logic [31:0] exp_pc);
    stall       = st;
    jump_valid  = jv;
    jump_target = jt;
    exc_req     = exc;
    eret_req    = eret;
    epc         = ep;
    im_rdy      = rdy;
    push_exp({tag, "_if_valid"}, {31'b0, exp_ifv});
    push_exp({tag, "_pc"}, exp_pc);
    #1;
    pop_chk({31'b0, if_valid});
    @(posedge clk);
    #1;
    pop_chk(pc);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    push_exp(tag, {31'b0, exp});
    pop_chk({31'b0, obs});
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_chk(obs);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    jump_valid  = 1'b0;
    jump_target = 32'h0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    epc         = 32'h0;
    im_rdy      = 1'b1;

    // Reset state.
    #2;
    chk32("rst_pc", pc, 32'h0000_3000);
    chk1("rst_im_req", im_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_adel", fetch_adel, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // BOOT cycle then sequential fetch.
    #1;
    chk1("boot_im_req", im_req, 1'b0);
    cyc("boot",  0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0000_3000);
    chk1("run_im_req", im_req, 1'b1);
    chk32("run_im_addr", im_addr, 32'h0000_3000);
    cyc("seq0",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_3004);
    cyc("seq1",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_3008);
    cyc("seq2",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_300c);
    cyc("seq3",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_3010);

    // Immediate redirect: delay slot completes in the jump cycle.
    cyc("jmp_now", 0, 1, 32'h0000_3100, 0, 0, 32'h0, 1, 1, 32'h0000_3100);
    chk32("jmp_pc_4", pc_4, 32'h0000_3104);

    // Deferred redirect: delay slot waits two cycles on IM.
    cyc("jmp_w0",  0, 1, 32'h0000_3020, 0, 0, 32'h0, 0, 0, 32'h0000_3100);
    cyc("jmp_w1",  0, 1, 32'h0000_3020, 0, 0, 32'h0, 0, 0, 32'h0000_3100);
    cyc("jmp_rdy", 0, 0, 32'h0,         0, 0, 32'h0, 1, 1, 32'h0000_3020);
    cyc("jmp_aft", 0, 0, 32'h0,         0, 0, 32'h0, 1, 1, 32'h0000_3024);

    // Stall freezes PC and drops the jump.
    cyc("stall0", 1, 1, 32'h0000_3300, 0, 0, 32'h0, 1, 0, 32'h0000_3024);
    cyc("stall1", 1, 1, 32'h0000_3300, 0, 0, 32'h0, 1, 0, 32'h0000_3024);
    cyc("stall2", 1, 1, 32'h0000_3300, 0, 0, 32'h0, 1, 0, 32'h0000_3024);
    cyc("unstall", 0, 0, 32'h0,        0, 0, 32'h0, 1, 1, 32'h0000_3028);

    // Exception in WAIT with a pending redirect, then eret.
    cyc("pend_set", 0, 1, 32'h0000_3400, 0, 0, 32'h0, 0, 0, 32'h0000_3028);
    cyc("exc",      0, 0, 32'h0,         1, 0, 32'h0, 0, 0, 32'h0000_4180);
    chk1("exc_im_req", im_req, 1'b1);
    cyc("exc_seq",  0, 0, 32'h0,         0, 0, 32'h0, 1, 1, 32'h0000_4184);
    cyc("eret",     0, 0, 32'h0, 0, 1, 32'h0000_3024, 1, 0, 32'h0000_3024);
    cyc("eret_seq", 0, 0, 32'h0,         0, 0, 32'h0, 1, 1, 32'h0000_3028);

    // Exception overrides a stall.
    cyc("exc_stall", 1, 0, 32'h0,        1, 0, 32'h0, 1, 0, 32'h0000_4180);

    // Fetch address legality boundaries.
    cyc("adel_mis", 0, 1, 32'h0000_3002, 0, 0, 32'h0, 1, 1, 32'h0000_3002);
    chk1("adel_mis_flag", fetch_adel, 1'b1);
    cyc("adel_hi",  0, 1, 32'h0000_5000, 0, 0, 32'h0, 1, 1, 32'h0000_5000);
    chk1("adel_hi_flag", fetch_adel, 1'b1);
    cyc("adel_top", 0, 1, 32'h0000_4ffc, 0, 0, 32'h0, 1, 1, 32'h0000_4ffc);
    chk1("adel_top_flag", fetch_adel, 1'b0);
    chk32("adel_top_pc_4", pc_4, 32'h0000_5000);
    cyc("adel_lo",  0, 1, 32'h0000_2ffc, 0, 0, 32'h0, 1, 1, 32'h0000_2ffc);
    chk1("adel_lo_flag", fetch_adel, 1'b1);
    cyc("adel_bot", 0, 1, 32'h0000_3000, 0, 0, 32'h0, 1, 1, 32'h0000_3000);
    chk1("adel_bot_flag", fetch_adel, 1'b0);

    // PC+4 wraps at the top of the address space.
    cyc("wrap", 0, 1, 32'hffff_fffc, 0, 0, 32'h0, 1, 1, 32'hffff_fffc);
    chk32("wrap_pc_4", pc_4, 32'h0000_0000);

    // Asynchronous reset in WAIT with a redirect pending.
    cyc("rst_pend", 0, 1, 32'h0000_3500, 0, 0, 32'h0, 0, 0, 32'hffff_fffc);
    jump_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk32("async_rst_pc", pc, 32'h0000_3000);
    chk1("async_rst_im_req", im_req, 1'b0);
    chk1("async_rst_if_valid", if_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("reboot",  0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0000_3000);
    cyc("reseq0",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_3004);
    cyc("reseq1",  0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0000_3008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Owns the fetch PC register and sequences it for the pipelined MIPS core.
- Arbitrates between four PC sources: sequential PC+4, the branch/jump target from the ID-stage next-PC logic, exception entry, and eret return.
- Honours hazard stalls, the instruction-memory ready handshake and the branch delay slot.
- Sits between the hazard unit, CP0, the ID-stage next-PC logic and IM; feeds PC/PC_4 into the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_4ffc, highest legal fetch address.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: freeze PC and IF/ID.
- jump_valid  in  1  ID stage: taken branch/j/jr this cycle (if_jump).
- jump_target  in  32  ID stage: redirect target (next_pc).
- exc_req  in  1  CP0: take exception/interrupt.
- eret_req  in  1  CP0: return from exception.
- epc  in  32  CP0 EPC value.
- im_rdy  in  1  IM: instruction for im_addr is available this cycle.
- im_req  out  1  fetch request valid.
- im_addr  out  32  fetch address (= pc).
- pc  out  32  current fetch PC.
- pc_4  out  32  pc + 4.
- if_valid  out  1  write a real instruction into IF/ID this cycle; 0 writes a bubble.
- fetch_adel  out  1  current pc misaligned or outside [IM_LO, IM_HI].

Behaviour:
- State machine BOOT/RUN/WAIT, plus a pending-redirect register (pend_v, pend_tgt).
- Reset (asynchronous): pc=RESET_PC, state=BOOT, pend_v=0. im_req, if_valid and fetch_adel are all 0 during reset.
- BOOT: im_req=0, lasts exactly one cycle after reset deasserts, then goes to RUN.
- RUN/WAIT: im_req=1, im_addr=pc.
  - A cycle with im_rdy=0 moves to WAIT.
  - A cycle with im_rdy=1 moves to RUN.
- fetch_done = im_req & im_rdy & ~stall.
- PC update priority at each edge (first match wins):
  1. exc_req: pc<=EXC_ENTRY, pend_v<=0, state<=RUN. Ignores stall and im_rdy; the in-flight fetch is abandoned.
  2. eret_req: pc<=epc, pend_v<=0, state<=RUN. Same override rules as exc_req.
  3. jump_valid & ~stall & fetch_done: pc<=jump_target. The fetch completing now is the delay slot.
  4. jump_valid & ~stall & ~fetch_done: pend_v<=1, pend_tgt<=jump_target; pc held.
  5. pend_v & fetch_done: pc<=pend_tgt, pend_v<=0.
  6. fetch_done: pc<=pc+4.
  7. Otherwise: pc held.
- jump_valid with stall=1 is ignored; the ID stage re-presents it once the stall clears.
- A second jump_valid while pend_v=1 overwrites pend_tgt. This is legal only under a CP0 fault; no assertion is required.
- if_valid = fetch_done & ~exc_req & ~eret_req. A stall cycle or a mem-wait cycle gives if_valid=0.
- pc_4 = pc+4, modulo 2^32. Wrap from 32'hffff_fffc to 0 is permitted.
- fetch_adel = im_req & (pc[1:0]!=0 | pc<IM_LO | pc>IM_HI). Combinational; CP0 samples it with if_valid.
- Latency: a redirect becomes visible on pc one edge after the delay-slot fetch completes. Exceptions take effect next edge.
- Reset asserted mid-WAIT or with pend_v=1: all state clears immediately, with no redirect leakage.

Decomposition:
- Add RESET_PC, EXC_ENTRY, IM_LO and IM_HI as `define constants in the shared head.v, next to the NPC_SL encodings.
- Add the state encodings FPC_BOOT/FPC_RUN/FPC_WAIT (2-bit) to head.v.
- One natural sub-module: fetch_redirect_buf, holding pend_v/pend_tgt with set/consume/clear controls.

Test Plan:
- Reset then im_rdy=1 constant: pc=0x3000 in BOOT, then 0x3000, 0x3004, 0x3008; if_valid=0 in BOOT, 1 afterwards.
- jump_valid=1, jump_target=0x3100 at pc=0x3010, im_rdy=1 → next pc=0x3100. Hold jump with im_rdy=0 for 2 cycles → pc stays 0x3010, pend_v=1; on the edge of the im_rdy=1 cycle pc=0x3100.
- stall=1 for 3 cycles with im_rdy=1 and jump_valid=1 → pc frozen, if_valid=0, jump ignored; on release pc advances by +4.
- exc_req=1 in WAIT with pend_v=1 → next pc=0x4180, pend_v=0, state=RUN. Then eret_req=1, epc=0x3024 → pc=0x3024.
- jump_target=0x3002 → after redirect fetch_adel=1. Target 0x5000 → fetch_adel=1. Target 0x4ffc → fetch_adel=0.
- Assert reset asynchronously mid-WAIT → pc=0x3000 and im_req=0 before the next clk edge.
